paddle_ctrl: RTL and testbench
==============================

PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 250000, number of consecutive stable clocks (10 ms at 25 MHz) before a debounced button changes state; legal range 2 to 262143.
REQ-002 Parameter SCREEN_H, default 480, visible line count.
REQ-003 Parameter PADDLE_H, default 64, paddle height in lines.
REQ-004 Parameter STEP, default 4, lines moved per frame tick.
REQ-005 clk  input  1  pixel clock, 25 MHz; all logic on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 btn_up  input  1  raw asynchronous up button, active high.
REQ-008 btn_down  input  1  raw asynchronous down button, active high.
REQ-009 frame_tick  input  1  one-clock pulse per frame, synchronous to clk.
REQ-010 center  input  1  synchronous recenter request, active high.
REQ-011 paddle_y  output  10  registered top line of paddle.
REQ-012 up_db  output  1  registered debounced up state.
REQ-013 down_db  output  1  registered debounced down state.

Function
REQ-014 Each button SHALL pass through a two-flop synchronizer before any other use.
REQ-015 Each button SHALL have its own 18-bit debounce counter; counter clears whenever synced value equals debounced value.
REQ-016 While synced differs from debounced, counter SHALL increment each clock; on the clock it equals DB_CYCLES-1, debounced takes synced value and counter clears.
REQ-017 Any return of synced to debounced value before that point SHALL clear the counter, discarding the glitch.
REQ-018 Latency from raw edge to up_db/down_db change SHALL be 2 + DB_CYCLES clocks for a clean step.
REQ-019 paddle_y SHALL change only on a clock where frame_tick or center is high; otherwise it holds.
REQ-020 center high SHALL load paddle_y = (SCREEN_H-PADDLE_H)/2 (208 default), overriding frame_tick in the same clock.
REQ-021 On frame_tick with up_db=1, down_db=0: paddle_y <= paddle_y-STEP if paddle_y >= STEP, else 0.
REQ-022 On frame_tick with down_db=1, up_db=0: paddle_y <= paddle_y+STEP if result <= SCREEN_H-PADDLE_H (416 default), else SCREEN_H-PADDLE_H.
REQ-023 On frame_tick with both or neither debounced button high: paddle_y holds.
REQ-024 Movement SHALL use debounced values registered before the tick edge; a debounce transition on the tick clock takes effect at the next tick.
REQ-025 paddle_y arithmetic SHALL be computed at 11 bits so no wrap-around occurs; paddle_y never leaves 0..SCREEN_H-PADDLE_H.
REQ-026 paddle_y update SHALL appear one clock after the sampling edge (registered output, no combinational path from inputs).

Reset
REQ-027 rst_n low SHALL asynchronously force paddle_y=(SCREEN_H-PADDLE_H)/2, up_db=0, down_db=0, synchronizer flops=0, counters=0.
REQ-028 Reset asserted mid-debounce or mid-move SHALL discard all progress; after release, a held button requires the full 2+DB_CYCLES clocks again.
REQ-029 Release of rst_n SHALL be handled as an asynchronous assert with operation resuming on the first rising clk edge after release.

Verification (DB_CYCLES=4, other defaults)
REQ-030 Reset, no input, 10 frame ticks -> paddle_y=208, up_db=down_db=0 throughout.
REQ-031 btn_up held -> up_db rises exactly 6 clocks after edge; next frame_tick -> paddle_y=204; 60 further ticks -> paddle_y=0 and stays 0.
REQ-032 btn_down held from 208 -> 52 ticks reach 416; further ticks -> stays 416, never 420.
REQ-033 btn_up pulse of 3 clocks, then low -> up_db never rises; paddle_y unchanged across ticks.
REQ-034 Both buttons held and debounced, 5 ticks -> paddle_y unchanged; center and frame_tick asserted together at paddle_y=100 with up_db=1 -> paddle_y=208.
REQ-035 rst_n pulsed low while counter at 3 and paddle_y=0 -> immediately paddle_y=208, up_db=0; held button re-debounces in 6 clocks after release.

Source files
------------

// File: rtl/paddle_ctrl_if.sv
// ---------------------------------------------------------------------------
// paddle_ctrl_if : button, frame and paddle-position signals of paddle_ctrl
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface paddle_ctrl_if;
  logic       btn_up;
  logic       btn_down;
  logic       frame_tick;
  logic       center;
  logic [9:0] paddle_y;
  logic       up_db;
  logic       down_db;

  modport master (
    output btn_up, btn_down, frame_tick, center,
    input  paddle_y, up_db, down_db
  );

  modport slave (
    input  btn_up, btn_down, frame_tick, center,
    output paddle_y, up_db, down_db
  );
endinterface

`default_nettype wire

// File: rtl/paddle_ctrl.sv
// ---------------------------------------------------------------------------
// paddle_ctrl : debounced two-button paddle position controller
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module paddle_ctrl #(
  parameter int DB_CYCLES = 250000,
  parameter int SCREEN_H  = 480,
  parameter int PADDLE_H  = 64,
  parameter int STEP      = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  paddle_ctrl_if.slave  bus
);

  localparam logic [17:0] c_db_last = 18'(DB_CYCLES - 1);
  localparam logic [10:0] c_max     = 11'(SCREEN_H - PADDLE_H);
  localparam logic [10:0] c_center  = 11'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [10:0] c_step    = 11'(STEP);

  logic [1:0]  w_raw;
  logic [1:0]  w_db;
  logic [9:0]  r_y;
  logic [10:0] w_y;
  logic [10:0] w_sum;
  logic [10:0] w_next;

  assign w_raw = {bus.btn_down, bus.btn_up};

  // Index 0 is the up button, index 1 the down button.
  generate
    for (genvar i = 0; i < 2; i++) begin : g_btn
      logic        r_sync1;
      logic        r_sync2;
      logic        r_db;
      logic [17:0] r_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sync1 <= 1'b0;
          r_sync2 <= 1'b0;
          r_db    <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_sync1 <= w_raw[i];
          r_sync2 <= r_sync1;
          if (r_sync2 == r_db) begin
            r_cnt <= '0;
          end else if (r_cnt == c_db_last) begin
            r_db  <= r_sync2;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 18'd1;
          end
        end
      end

      assign w_db[i] = r_db;
    end
  endgenerate

  // Widened by one bit so neither the step down nor the step up can wrap.
  assign w_y   = {1'b0, r_y};
  assign w_sum = w_y + c_step;

  always_comb begin
    w_next = w_y;
    if (bus.center) begin
      w_next = c_center;
    end else if (bus.frame_tick) begin
      if (w_db[0] && !w_db[1]) begin
        w_next = (w_y >= c_step) ? (w_y - c_step) : 11'd0;
      end else if (w_db[1] && !w_db[0]) begin
        w_next = (w_sum <= c_max) ? w_sum : c_max;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y <= c_center[9:0];
    end else begin
      r_y <= w_next[9:0];
    end
  end

  assign bus.paddle_y = r_y;
  assign bus.up_db    = w_db[0];
  assign bus.down_db  = w_db[1];

endmodule

`default_nettype wire

// File: tb/tb_paddle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_paddle_ctrl : directed self-checking bench for paddle_ctrl (DB_CYCLES=4)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_paddle_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  paddle_ctrl_if pif ();

  paddle_ctrl #(
    .DB_CYCLES (4),
    .SCREEN_H  (480),
    .PADDLE_H  (64),
    .STEP      (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame();
    pif.frame_tick = 1'b1;
    @(negedge clk);
    pif.frame_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic recenter();
    pif.center = 1'b1;
    @(negedge clk);
    pif.center = 1'b0;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    pif.btn_up     = 1'b0;
    pif.btn_down   = 1'b0;
    pif.frame_tick = 1'b0;
    pif.center     = 1'b0;
    clocks(3);
    n_checks++;
    if (pif.paddle_y !== 10'd208 || pif.up_db !== 1'b0 || pif.down_db !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: y=%0d up=%b dn=%b, need y=208 up=0 dn=0",
               pif.paddle_y, pif.up_db, pif.down_db);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      frame();
      n_checks++;
      if (pif.paddle_y !== 10'd208 || pif.up_db !== 1'b0 || pif.down_db !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_tick%0d: y=%0d up=%b dn=%b, need y=208 up=0 dn=0",
                 k, pif.paddle_y, pif.up_db, pif.down_db);
      end
    end
  endtask

  task automatic test_up_move();
    pif.btn_up = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      n_checks++;
      if (pif.up_db !== (k == 6)) begin
        n_fail++;
        $display("FAIL up_latency clk%0d: up_db=%b, need %b", k, pif.up_db, (k == 6));
      end
    end
    frame();
    n_checks++;
    if (pif.paddle_y !== 10'd204) begin
      n_fail++;
      $display("FAIL up_first_step: y=%0d, need 204", pif.paddle_y);
    end
    for (int k = 0; k < 60; k++) frame();
    n_checks++;
    if (pif.paddle_y !== 10'd0) begin
      n_fail++;
      $display("FAIL up_clamp: y=%0d, need 0", pif.paddle_y);
    end
    frame();
    frame();
    n_checks++;
    if (pif.paddle_y !== 10'd0) begin
      n_fail++;
      $display("FAIL up_stay0: y=%0d, need 0", pif.paddle_y);
    end
    pif.btn_up = 1'b0;
    clocks(8);
    n_checks++;
    if (pif.up_db !== 1'b0) begin
      n_fail++;
      $display("FAIL up_release: up_db=%b, need 0", pif.up_db);
    end
  endtask

  task automatic test_down_clamp();
    recenter();
    n_checks++;
    if (pif.paddle_y !== 10'd208) begin
      n_fail++;
      $display("FAIL center_load: y=%0d, need 208", pif.paddle_y);
    end
    pif.btn_down = 1'b1;
    clocks(6);
    n_checks++;
    if (pif.down_db !== 1'b1) begin
      n_fail++;
      $display("FAIL down_latency: down_db=%b, need 1", pif.down_db);
    end
    for (int k = 0; k < 51; k++) frame();
    n_checks++;
    if (pif.paddle_y !== 10'd412) begin
      n_fail++;
      $display("FAIL down_51: y=%0d, need 412", pif.paddle_y);
    end
    frame();
    n_checks++;
    if (pif.paddle_y !== 10'd416) begin
      n_fail++;
      $display("FAIL down_52: y=%0d, need 416", pif.paddle_y);
    end
    for (int k = 0; k < 3; k++) begin
      frame();
      n_checks++;
      if (pif.paddle_y !== 10'd416) begin
        n_fail++;
        $display("FAIL down_clamp%0d: y=%0d, need 416", k, pif.paddle_y);
      end
    end
    pif.btn_down = 1'b0;
    clocks(8);
  endtask

  task automatic test_glitch();
    pif.btn_up = 1'b1;
    clocks(3);
    pif.btn_up = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (pif.up_db !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch_clk%0d: up_db=%b, need 0", k, pif.up_db);
      end
    end
    for (int k = 0; k < 3; k++) frame();
    n_checks++;
    if (pif.paddle_y !== 10'd416) begin
      n_fail++;
      $display("FAIL glitch_hold: y=%0d, need 416", pif.paddle_y);
    end
  endtask

  task automatic test_both_and_center();
    pif.btn_up   = 1'b1;
    pif.btn_down = 1'b1;
    clocks(8);
    n_checks++;
    if (pif.up_db !== 1'b1 || pif.down_db !== 1'b1) begin
      n_fail++;
      $display("FAIL both_db: up=%b dn=%b, need 1 1", pif.up_db, pif.down_db);
    end
    for (int k = 0; k < 5; k++) frame();
    n_checks++;
    if (pif.paddle_y !== 10'd416) begin
      n_fail++;
      $display("FAIL both_hold: y=%0d, need 416", pif.paddle_y);
    end
    pif.btn_down = 1'b0;
    clocks(8);
    recenter();
    for (int k = 0; k < 27; k++) frame();
    n_checks++;
    if (pif.paddle_y !== 10'd100 || pif.up_db !== 1'b1 || pif.down_db !== 1'b0) begin
      n_fail++;
      $display("FAIL reach_100: y=%0d up=%b dn=%b, need y=100 up=1 dn=0",
               pif.paddle_y, pif.up_db, pif.down_db);
    end
    pif.center     = 1'b1;
    pif.frame_tick = 1'b1;
    @(negedge clk);
    pif.center     = 1'b0;
    pif.frame_tick = 1'b0;
    n_checks++;
    if (pif.paddle_y !== 10'd208) begin
      n_fail++;
      $display("FAIL center_override: y=%0d, need 208", pif.paddle_y);
    end
  endtask

  task automatic test_reset_mid_debounce();
    for (int k = 0; k < 52; k++) frame();
    n_checks++;
    if (pif.paddle_y !== 10'd0) begin
      n_fail++;
      $display("FAIL pre_reset_y: y=%0d, need 0", pif.paddle_y);
    end
    pif.btn_up = 1'b0;
    clocks(8);
    pif.btn_up = 1'b1;
    clocks(5);
    n_checks++;
    if (pif.up_db !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_reset_db: up_db=%b, need 0", pif.up_db);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (pif.paddle_y !== 10'd208 || pif.up_db !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: y=%0d up=%b, need y=208 up=0", pif.paddle_y, pif.up_db);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      n_checks++;
      if (pif.up_db !== (k == 6) || pif.paddle_y !== 10'd208) begin
        n_fail++;
        $display("FAIL redebounce clk%0d: up=%b y=%0d, need up=%b y=208",
                 k, pif.up_db, pif.paddle_y, (k == 6));
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_up_move();
    test_down_clamp();
    test_glitch();
    test_both_and_center();
    test_reset_mid_debounce();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
